// File: rtl/maquina_monitor.sv
// Observer for the coffee-machine sequencer: checks transitions, dwell and refills; counts cups.
// Optional macro MAQUINA_MONITOR_TIMING_EN adds last_cup_cycles (cycles from LIGAR entry to cup done).
module maquina_monitor #(
    parameter int MAX_DWELL   = 16,
    parameter int MAX_REFILLS = 3,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       state,
    input  logic             clr,
    output logic             cafe_pronto,
    output logic [CNT_W-1:0] cups,
    output logic [CNT_W-1:0] refills,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [3:0]       err_state
`ifdef MAQUINA_MONITOR_TIMING_EN
    ,
    output logic [15:0]      last_cup_cycles
`endif
);
    localparam logic [3:0] S_IDLE = 4'd1, S_LIG = 4'd2, S_VER = 4'd3, S_ENC = 4'd4, S_MOER = 4'd5,
                           S_COL = 4'd6, S_PAS = 4'd7, S_TAM = 4'd8, S_EXT = 4'd9;
    localparam int REF_W = $clog2(MAX_REFILLS + 2);
    localparam logic [REF_W-1:0] REF_LIM = REF_W'(MAX_REFILLS);
    localparam logic [REF_W-1:0] REF_SAT = REF_W'(MAX_REFILLS + 1);
    localparam logic [15:0] DW_MAX = 16'(MAX_DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    function automatic logic legal(input logic [3:0] p, input logic [3:0] s);
        if (p == s) return 1'b1;
        case (p)
            S_IDLE:  return s == S_LIG;
            S_LIG:   return s == S_VER;
            S_VER:   return s == S_ENC || s == S_MOER;
            S_ENC:   return s == S_VER;
            S_MOER:  return s == S_COL;
            S_COL:   return s == S_PAS;
            S_PAS:   return s == S_TAM;
            S_TAM:   return s == S_EXT;
            S_EXT:   return s == S_IDLE;
            default: return 1'b0;
        endcase
    endfunction

    logic [3:0]       prev_q, prev_d;
    logic [15:0]      dwell_q, dwell_d;
    logic [REF_W-1:0] cupref_q, cupref_d;
    logic             cafe_q, cafe_d, err_q, err_d;
    logic [CNT_W-1:0] cups_q, cups_d, refills_q, refills_d;
    logic [2:0]       code_q, code_d, fault;
    logic [3:0]       estate_q, estate_d;
    logic             same, done, enc_in, lig_in;

    always_comb begin
        same   = state == prev_q;
        done   = prev_q == S_EXT && state == S_IDLE;
        enc_in = state == S_ENC && prev_q != S_ENC;
        lig_in = state == S_LIG && prev_q != S_LIG;
        prev_d = state;

        dwell_d = dwell_q;
        if (!same || state == S_IDLE)  dwell_d = '0;
        else if (dwell_q != DW_MAX)    dwell_d = dwell_q + 16'd1;

        cupref_d = cupref_q;
        if (done || lig_in)                     cupref_d = '0;
        else if (enc_in && cupref_q != REF_SAT) cupref_d = cupref_q + 1'b1;

        fault = 3'd0;
        if (state == 4'd0 || state > S_EXT)                     fault = 3'd1;
        else if (!legal(prev_q, state))                         fault = 3'd2;
        else if (enc_in && cupref_q >= REF_LIM)                 fault = 3'd3;
        else if (same && state != S_IDLE && dwell_d == DW_MAX)  fault = 3'd4;

        cafe_d = done;
        // Same-cycle events survive clr: the cleared value restarts from them.
        cups_d    = clr ? CNT_W'(done)   : (done   && cups_q    != CNT_SAT) ? cups_q + 1'b1    : cups_q;
        refills_d = clr ? CNT_W'(enc_in) : (enc_in && refills_q != CNT_SAT) ? refills_q + 1'b1 : refills_q;

        err_d    = clr ? 1'b0 : err_q;
        code_d   = clr ? 3'd0 : code_q;
        estate_d = clr ? 4'd0 : estate_q;
        if (fault != 3'd0 && (!err_q || clr)) begin
            err_d    = 1'b1;
            code_d   = fault;
            estate_d = state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= S_IDLE;
            dwell_q   <= '0;
            cupref_q  <= '0;
            cafe_q    <= 1'b0;
            cups_q    <= '0;
            refills_q <= '0;
            err_q     <= 1'b0;
            code_q    <= 3'd0;
            estate_q  <= 4'd0;
        end else begin
            prev_q    <= prev_d;
            dwell_q   <= dwell_d;
            cupref_q  <= cupref_d;
            cafe_q    <= cafe_d;
            cups_q    <= cups_d;
            refills_q <= refills_d;
            err_q     <= err_d;
            code_q    <= code_d;
            estate_q  <= estate_d;
        end
    end

    assign cafe_pronto = cafe_q;
    assign cups        = cups_q;
    assign refills     = refills_q;
    assign err         = err_q;
    assign err_code    = code_q;
    assign err_state   = estate_q;

`ifdef MAQUINA_MONITOR_TIMING_EN
    logic [15:0] tcnt_q, tcnt_d, last_q, last_d, tinc;

    always_comb begin
        tinc   = (tcnt_q != 16'hFFFF) ? tcnt_q + 16'd1 : tcnt_q;
        tcnt_d = lig_in ? 16'd1 : tinc;
        last_d = done ? tinc : (clr ? 16'd0 : last_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q <= '0;
            last_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
            last_q <= last_d;
        end
    end

    assign last_cup_cycles = last_q;
`endif
endmodule

// File: tb/tb_maquina_monitor.sv
// Directed bench for maquina_monitor; a second instance with CNT_W=2 checks counter saturation.
module tb_maquina_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] state = 4'd1;
    logic       clr = 1'b0;
    logic       cafe, err, cafe2, err2;
    logic [7:0] cups, refills;
    logic [1:0] cups2, refills2;
    logic [2:0] code, code2;
    logic [3:0] estate, estate2;
`ifdef MAQUINA_MONITOR_TIMING_EN
    logic [15:0] lcc, lcc2;
`endif
    int tests = 0, failed = 0;

    always #5 clk = ~clk;

    maquina_monitor #(.MAX_DWELL(16), .MAX_REFILLS(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .state(state), .clr(clr), .cafe_pronto(cafe), .cups(cups),
        .refills(refills), .err(err), .err_code(code), .err_state(estate)
`ifdef MAQUINA_MONITOR_TIMING_EN
        , .last_cup_cycles(lcc)
`endif
    );

    maquina_monitor #(.MAX_DWELL(16), .MAX_REFILLS(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .state(state), .clr(clr), .cafe_pronto(cafe2), .cups(cups2),
        .refills(refills2), .err(err2), .err_code(code2), .err_state(estate2)
`ifdef MAQUINA_MONITOR_TIMING_EN
        , .last_cup_cycles(lcc2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] s, input logic c = 1'b0);
        state = s;
        clr   = c;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic cup_tail;
        step(4'd5); step(4'd6); step(4'd7); step(4'd8); step(4'd9); step(4'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cafe", cafe, 0); chk("rst_cups", cups, 0); chk("rst_refills", refills, 0);
        chk("rst_err", err, 0); chk("rst_code", code, 0); chk("rst_estate", estate, 0);
        rst = 1'b0;

        // nominal cup with one refill
        step(4'd1); step(4'd2); step(4'd3); step(4'd4); step(4'd3);
        step(4'd5); step(4'd6); step(4'd7); step(4'd8); step(4'd9);
        chk("nom_cafe_before", cafe, 0);
        step(4'd1);
        chk("nom_cafe", cafe, 1); chk("nom_cups", cups, 1); chk("nom_refills", refills, 1);
        chk("nom_err", err, 0);
`ifdef MAQUINA_MONITOR_TIMING_EN
        chk("nom_timing", lcc, 10);
`endif
        step(4'd1);
        chk("nom_cafe_pulse", cafe, 0);

        // illegal transition LIGAR -> MOER
        step(4'd2); step(4'd5);
        chk("tr_err", err, 1); chk("tr_code", code, 2); chk("tr_estate", estate, 5);
        step(4'd1); step(4'd2); step(4'd3); cup_tail();
        chk("tr_cups", cups, 2); chk("tr_code_kept", code, 2); chk("tr_estate_kept", estate, 5);

        step(4'd1, 1'b1);
        chk("clr_err", err, 0); chk("clr_code", code, 0); chk("clr_cups", cups, 0);
        chk("clr_refills", refills, 0);

        // illegal encoding, then back to IDLE, then clear
        step(4'd12);
        chk("enc_code", code, 1); chk("enc_estate", estate, 12);
        step(4'd1);
        chk("enc_code_kept", code, 1);
        step(4'd1, 1'b1);
        chk("enc_clr_err", err, 0); chk("enc_clr_code", code, 0); chk("enc_clr_estate", estate, 0);

        // fault in the same cycle as clr is captured
        step(4'd0, 1'b1);
        chk("clrfault_err", err, 1); chk("clrfault_code", code, 1); chk("clrfault_estate", estate, 0);
        step(4'd1); step(4'd1, 1'b1);
        chk("clrfault_clear", err, 0);

        // refill limit
        step(4'd2);
        for (int i = 0; i < 3; i++) begin step(4'd3); step(4'd4); end
        chk("ref3_err", err, 0); chk("ref3_refills", refills, 3);
        step(4'd3); step(4'd4);
        chk("ref4_code", code, 3); chk("ref4_estate", estate, 4); chk("ref4_refills", refills, 4);
        step(4'd3); cup_tail();
        step(4'd1, 1'b1);
        // per-cup counter was cleared by the cup: three refills are legal again
        step(4'd2);
        for (int i = 0; i < 3; i++) begin step(4'd3); step(4'd4); end
        chk("ref_percup_reset", err, 0);
        step(4'd3); cup_tail();
        step(4'd1, 1'b1);

        // dwell watchdog on MOER
        step(4'd2); step(4'd3);
        for (int i = 0; i < 15; i++) step(4'd5);
        chk("wd_15_err", err, 0);
        step(4'd5);
        chk("wd_16_err", err, 1); chk("wd_code", code, 4); chk("wd_estate", estate, 5);
        step(4'd6); step(4'd7); step(4'd8); step(4'd9); step(4'd1);
        step(4'd1, 1'b1);
        for (int i = 0; i < 100; i++) step(4'd1);
        chk("wd_idle_err", err, 0);

        // cup done coincident with clr leaves cups=1
        step(4'd2); step(4'd3); step(4'd5); step(4'd6); step(4'd7); step(4'd8); step(4'd9);
        step(4'd1, 1'b1);
        chk("clrcup_cups", cups, 1); chk("clrcup_cafe", cafe, 1);

        // asynchronous reset during TAMPEAR after a fault
        step(4'd2); step(4'd5); step(4'd6); step(4'd7); step(4'd8);
        chk("pre_rst_err", err, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_cups", cups, 0); chk("arst_err", err, 0); chk("arst_code", code, 0);
        chk("arst_estate", estate, 0); chk("arst_cafe", cafe, 0); chk("arst_refills", refills, 0);
        @(posedge clk); #1 rst = 1'b0;
        step(4'd1); step(4'd2);
        chk("resume_err", err, 0);
        step(4'd3); cup_tail();
        #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        step(4'd3);
        chk("rst_verif_code", code, 2); chk("rst_verif_estate", estate, 3);
        #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // five cups: 8-bit counter reaches 5, 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin step(4'd1); step(4'd2); step(4'd3); cup_tail(); end
        chk("sat_cups8", cups, 5); chk("sat_cups2", cups2, 3); chk("sat_err", err, 0);
        chk("sat_err2", err2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
